// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO in front of it.
// Words are pushed with a valid/ready handshake, queued, and sent as
// start + DATA_BITS (LSB first) + optional parity + STOP_BITS stop bits.
// The serial line is driven from a flop one cycle behind the FSM state.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 10416,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;

    // Transmit engine
    state_t               state;
    state_t               state_next;
    logic [15:0]          bit_cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] frame_data;
    logic                 bit_done;
    logic                 par_bit;
    logic                 line_next;
    logic                 idx_clr;
    logic                 idx_inc;

    assign fifo_empty = (count == '0);
    // Ready depends on occupancy only, so a pop in the same cycle never
    // opens a slot early and a full FIFO is never written.
    assign tx_ready   = (count < CW'(FIFO_DEPTH));
    assign push       = tx_valid && tx_ready;
    assign fifo_count = count;
    assign busy       = (state != IDLE) || (count != '0);

    assign bit_done   = (bit_cnt == 16'(CLK_DIV - 1));
    assign par_bit    = (PARITY == 2) ? (^frame_data) : ~(^frame_data);

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // FIFO data array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; emptiness is
        // tracked by count, so stale entries are never read.
        if (push && !reset) mem[wr_ptr] <= tx_data;
    end

    // Next-state, pop request and line value for the current bit.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned and no latch is inferred.
        state_next = state;
        pop        = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        line_next  = 1'b1;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                line_next = 1'b0;
                if (bit_done) begin
                    idx_clr    = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: begin
                line_next = frame_data[bit_idx];
                if (bit_done) begin
                    if (bit_idx == IW'(DATA_BITS - 1)) begin
                        idx_clr    = 1'b1;
                        state_next = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            PAR: begin
                line_next = par_bit;
                if (bit_done) begin
                    idx_clr    = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                line_next = 1'b1;
                if (bit_done) begin
                    if (bit_idx == IW'(STOP_BITS - 1)) begin
                        idx_clr = 1'b1;
                        // Chain straight into the next start bit when data is waiting.
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, bit timing, head-word capture and the registered line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            frame_data <= '0;
            uart_tx    <= 1'b1;
        end else begin
            state   <= state_next;
            uart_tx <= line_next;
            if (state == IDLE || bit_done) bit_cnt <= '0;
            else                           bit_cnt <= bit_cnt + 1'b1;
            if (idx_clr)      bit_idx <= '0;
            else if (idx_inc) bit_idx <= bit_idx + 1'b1;
            if (pop) frame_data <= mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three parameter sets run side by side. Each has a
// driver that pushes words into a scoreboard queue together with the push
// cycle, and a monitor that decodes frames from the serial line and compares
// them with a frame built from the framing rules and a predicted start cycle.
module tb_uart_tx_fifo;

    localparam int NCFG     = 3;
    localparam int CFG_DIV [NCFG] = '{4, 3, 4};
    localparam int CFG_DB  [NCFG] = '{8, 9, 7};
    localparam int CFG_PAR [NCFG] = '{2, 1, 0};
    localparam int CFG_SB  [NCFG] = '{1, 1, 2};
    localparam int CFG_DEP [NCFG] = '{16, 8, 4};
    localparam int WAIT_LIM = 4000;
    localparam int RUN_LIM  = 60000;

    typedef struct {
        logic [8:0] data;
        int         cyc;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges so far; read at falling edges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int cfg_id,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     cfg_id, name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int CD   = CFG_DIV[g];
        localparam int DB   = CFG_DB[g];
        localparam int PM   = CFG_PAR[g];
        localparam int SB   = CFG_SB[g];
        localparam int DEP  = CFG_DEP[g];
        localparam int NB   = 1 + DB + ((PM != 0) ? 1 : 0) + SB;
        localparam int FL   = NB * CD;
        localparam int MID  = (DEP > 5) ? 5 : DEP - 1;
        localparam int CNTW = $clog2(DEP) + 1;

        logic            rst;
        logic [DB-1:0]   tx_data;
        logic            tx_valid;
        logic            tx_ready;
        logic            uart_tx;
        logic            busy;
        logic [CNTW-1:0] fifo_count;

        sb_t sb[$];
        int  epoch     = 0;
        int  prev_end  = 0;
        int  last_push = 0;
        bit  done      = 1'b0;

        uart_tx_fifo #(
            .CLK_DIV   (CD),
            .DATA_BITS (DB),
            .PARITY    (PM),
            .STOP_BITS (SB),
            .FIFO_DEPTH(DEP)
        ) dut (
            .clk       (clk),
            .reset     (rst),
            .tx_data   (tx_data),
            .tx_valid  (tx_valid),
            .tx_ready  (tx_ready),
            .uart_tx   (uart_tx),
            .busy      (busy),
            .fifo_count(fifo_count)
        );

        always @(posedge clk) if (rst) epoch <= epoch + 1;

        // Line image of one frame, bit 0 first on the wire.
        function automatic logic [31:0] exp_frame(input logic [8:0] d);
            logic [31:0] f;
            int ones;
            f    = '0;
            ones = 0;
            for (int i = 0; i < DB; i++) begin
                f[1 + i] = d[i];
                ones += int'(d[i]);
            end
            if (PM == 2) f[1 + DB] = (ones % 2 == 1);
            if (PM == 1) f[1 + DB] = (ones % 2 == 0);
            for (int s = 0; s < SB; s++) f[NB - 1 - s] = 1'b1;
            return f;
        endfunction

        function automatic logic [8:0] rnd_word();
            return 9'($urandom_range(0, (1 << DB) - 1));
        endfunction

        // Call at a falling edge; returns at the falling edge after the push.
        task automatic push_word(input logic [8:0] d);
            int n = 0;
            tx_valid = 1'b1;
            tx_data  = DB'(d);
            while (!tx_ready && n < WAIT_LIM) begin
                @(negedge clk);
                n++;
            end
            check("push_accepted", g, 32'(tx_ready), 32'd1);
            if (tx_ready) begin
                sb.push_back(sb_t'{d, cyc + 1});
                last_push = cyc + 1;
            end
            @(negedge clk);
            tx_valid = 1'b0;
        endtask

        task automatic wait_idle();
            int n = 0;
            while ((busy || sb.size() != 0) && n < WAIT_LIM) begin
                @(negedge clk);
                n++;
            end
            check("drain_in_time", g, 32'(n < WAIT_LIM), 32'd1);
            repeat (3) @(negedge clk);
        endtask

        // Monitor: decode every frame on the line and score it.
        initial begin : mon
            int          seen_epoch;
            int          s;
            int          exp_start;
            bit          have;
            bit          glitch;
            bit          aborted;
            logic [31:0] act;
            sb_t         e;
            seen_epoch = 0;
            forever begin
                @(negedge clk);
                if (epoch != seen_epoch) begin
                    seen_epoch = epoch;
                    prev_end   = 0;
                end else if (uart_tx === 1'b0) begin
                    s    = cyc;
                    have = (sb.size() != 0);
                    check("frame_expected", g, 32'(have), 32'd1);
                    e = sb_t'{9'd0, 0};
                    if (have) e = sb.pop_front();
                    exp_start = (e.cyc + 2 > prev_end) ? e.cyc + 2 : prev_end;
                    prev_end  = s + FL;
                    act       = '0;
                    glitch    = 1'b0;
                    aborted   = 1'b0;
                    for (int j = 0; j < FL; j++) begin
                        if (j != 0) @(negedge clk);
                        if (epoch != seen_epoch) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (j % CD == 0)                 act[j / CD] = uart_tx;
                        else if (uart_tx !== act[j / CD]) glitch     = 1'b1;
                    end
                    if (aborted) begin
                        seen_epoch = epoch;
                        prev_end   = 0;
                    end else if (have) begin
                        check("frame_start_cycle", g, 32'(s), 32'(exp_start));
                        check("frame_bits", g, act, exp_frame(e.data));
                        check("bit_hold_cycles", g, 32'(glitch), 32'd0);
                    end
                end
            end
        end

        // Driver: directed scenarios with random data.
        initial begin : drv
            int         n;
            int         e0;
            int         s0;
            int         acc;
            logic [8:0] w;

            // Reset, with a push offered while reset is high.
            rst      = 1'b1;
            tx_valid = 1'b0;
            tx_data  = '0;
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = DB'(rnd_word());
            @(negedge clk);
            check("reset_uart_tx", g, 32'(uart_tx), 32'd1);
            check("reset_count_push_dropped", g, 32'(fifo_count), 32'd0);
            check("reset_busy", g, 32'(busy), 32'd0);
            check("reset_tx_ready", g, 32'(tx_ready), 32'd1);
            tx_valid = 1'b0;
            rst      = 1'b0;
            repeat (3) @(negedge clk);
            check("idle_after_reset_count", g, 32'(fifo_count), 32'd0);

            // Single word from idle: start bit appears two edges after the push.
            push_word(rnd_word());
            e0 = last_push;
            @(negedge clk);
            check("line_high_at_E+1", g, 32'(uart_tx), 32'd1);
            @(negedge clk);
            check("line_low_at_E+2", g, 32'(uart_tx), 32'd0);
            check("busy_during_frame", g, 32'(busy), 32'd1);
            n = 0;
            while (cyc < e0 + FL && n < WAIT_LIM) begin
                @(negedge clk);
                n++;
            end
            check("busy_in_stop_bit", g, 32'(busy), 32'd1);
            repeat (2) @(negedge clk);
            check("busy_low_after_stop", g, 32'(busy), 32'd0);
            check("line_idle_after_stop", g, 32'(uart_tx), 32'd1);
            wait_idle();

            // Offer a new word every cycle; refused words must never appear.
            acc = 0;
            for (int i = 0; i < 20; i++) begin
                tx_valid = 1'b1;
                tx_data  = DB'(i);
                if (tx_ready) begin
                    sb.push_back(sb_t'{9'(i), cyc + 1});
                    acc++;
                end
                @(negedge clk);
            end
            tx_valid = 1'b0;
            check("accepted_until_full", g, 32'(acc), 32'(DEP + 1));
            check("ready_low_when_full", g, 32'(tx_ready), 32'd0);
            check("count_when_full", g, 32'(fifo_count), 32'(DEP));
            wait_idle();

            // Push exactly on the edge where the engine pops the next word.
            for (int i = 0; i <= MID; i++) push_word(rnd_word());
            check("count_mid", g, 32'(fifo_count), 32'(MID));
            n = 0;
            while (cyc != prev_end - 2 && n < WAIT_LIM) begin
                @(negedge clk);
                n++;
            end
            check("reach_pop_edge", g, 32'(n < WAIT_LIM), 32'd1);
            check("ready_before_push_pop", g, 32'(tx_ready), 32'd1);
            w        = rnd_word();
            tx_valid = 1'b1;
            tx_data  = DB'(w);
            sb.push_back(sb_t'{w, cyc + 1});
            @(negedge clk);
            tx_valid = 1'b0;
            check("count_push_pop_same_edge", g, 32'(fifo_count), 32'(MID));
            wait_idle();

            // Stream of 40 words with random gaps; pointers wrap several times.
            for (int i = 0; i < 40; i++) begin
                push_word(rnd_word());
                if (i % 13 == 12) repeat (FL + 5) @(negedge clk);
                else              repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            wait_idle();
            check("count_after_stream", g, 32'(fifo_count), 32'd0);

            // Reset during the fourth data bit with two more words queued.
            push_word(rnd_word());
            s0 = last_push + 2;
            push_word(rnd_word());
            push_word(rnd_word());
            n = 0;
            while (cyc < s0 + 4 * CD + 1 && n < WAIT_LIM) begin
                @(negedge clk);
                n++;
            end
            check("line_in_data_before_reset", g, 32'(busy), 32'd1);
            sb.delete();
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("abort_uart_tx", g, 32'(uart_tx), 32'd1);
            check("abort_count", g, 32'(fifo_count), 32'd0);
            check("abort_busy", g, 32'(busy), 32'd0);
            check("abort_tx_ready", g, 32'(tx_ready), 32'd1);
            repeat (3 * FL) @(negedge clk);
            check("quiet_after_abort_busy", g, 32'(busy), 32'd0);
            check("quiet_after_abort_line", g, 32'(uart_tx), 32'd1);

            done = 1'b1;
        end
    end

    initial begin : summary
        int n;
        n = 0;
        while (!(cfg[0].done && cfg[1].done && cfg[2].done) && n < RUN_LIM) begin
            @(posedge clk);
            n++;
        end
        check("all_configs_finished", -1, 32'(n < RUN_LIM), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK_DIV, default 10416, clock cycles per bit; legal range 2..65535 (10416 gives 9600 baud at 100 MHz).
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 16, transmit FIFO entries; power of two, 2..256.
REQ-006 Port clk, input, 1, single clock for all logic.
REQ-007 Port reset, input, 1, synchronous active-high reset.
REQ-008 Port tx_data, input, DATA_BITS, word to transmit, LSB first on the line.
REQ-009 Port tx_valid, input, 1, tx_data valid this cycle.
REQ-010 Port tx_ready, output, 1, FIFO can accept a word this cycle.
REQ-011 Port uart_tx, output, 1, serial line, idle high, registered.
REQ-012 Port busy, output, 1, high while a frame is on the line or the FIFO is non-empty.
REQ-013 Port fifo_count, output, clog2(FIFO_DEPTH)+1, number of words held in the FIFO.

Function
REQ-014 A push occurs on a rising edge where tx_valid and tx_ready are both high; tx_ready = (fifo_count < FIFO_DEPTH), combinational from the count only, never from tx_valid.
REQ-015 When full, tx_ready is low even if a pop happens in the same cycle; no push to a full FIFO, no overwrite, no data loss.
REQ-016 Push and pop in the same cycle on a non-full, non-empty FIFO leave fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-017 FSM states: IDLE, START, DATA, PAR, STOP; one bit counter (0..CLK_DIV-1) and one bit index.
REQ-018 IDLE: uart_tx=1; if the FIFO is non-empty, pop the head word into the shift register and go to START.
REQ-019 START: uart_tx=0 for exactly CLK_DIV cycles, then DATA.
REQ-020 DATA: DATA_BITS bits LSB first, each held for exactly CLK_DIV cycles; then PAR if PARITY!=0, else STOP.
REQ-021 PAR: one bit for CLK_DIV cycles; even mode sends XOR of the data bits; odd mode sends its inverse.
REQ-022 STOP: uart_tx=1 for STOP_BITS*CLK_DIV cycles; on the last cycle, pop and go to START if the FIFO is non-empty, else go to IDLE.
REQ-023 Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
REQ-024 Latency: with the FIFO empty and the FSM in IDLE, a push on edge E drives uart_tx=0 after edge E+2.
REQ-025 uart_tx is driven from a flop; it has no combinational path from any input.
REQ-026 busy = (state != IDLE) or (fifo_count != 0).

Reset
REQ-027 With reset high at a rising edge: uart_tx=1, state=IDLE, fifo_count=0, busy=0, tx_ready=1, pointers and counters cleared.
REQ-028 Reset mid-frame aborts the frame: uart_tx=1 from the next edge, and all FIFO contents are discarded.
REQ-029 A push presented in the same cycle as reset is dropped.

Verification
REQ-030 Defaults; push 0xAA once -> uart_tx=0 after E+2; line then reads 0,1,0,1,0,1,0,1 (LSB first), stop=1; each bit exactly 10416 cycles; busy falls after the stop bit.
REQ-031 PARITY=2, CLK_DIV=4; push 0xCC -> parity bit 0. PARITY=1; push 0xCC -> parity bit 1. Frame length 11*4=44 cycles.
REQ-032 CLK_DIV=4, FIFO_DEPTH=16; hold tx_valid high with 0x00..0x13 -> tx_ready deasserts once 16 words are queued (first word popped); all accepted words transmitted in order with no gap; rejected words never appear.
REQ-033 DATA_BITS=7, STOP_BITS=2, CLK_DIV=4; push 0x55 -> 1 start + 7 data + 2 stop = 40 cycles; next frame's start bit follows with no idle cycle.
REQ-034 CLK_DIV=4; queue 3 words, assert reset for 1 cycle during the 4th data bit -> uart_tx=1 next cycle, fifo_count=0, busy=0; no further frame without new pushes.
REQ-035 Simultaneous push and pop at fifo_count=5 -> fifo_count stays 5; wrap test of 40 words through a depth-4 FIFO -> output order matches input order.
